cordic_host_seq: RTL and testbench
==================================

Name: cordic_host_seq

Overview:
- Host-side sequencer for the CORDIC iteration controller; it sits on the opposite end of the bgn/init/ld/fin interface.
- Accepts one angle request per job over a valid/ready handshake and holds the operand for the datapath.
- Drives bgn and owns the iteration counter that feeds the controller's itr input.
- Captures the datapath result when fin pulses and returns it over a valid/ready response handshake, with a watchdog timeout.

Parameters:
- rndw, 4, width of the iteration counter itr; the controller terminates at itr==15, so 4 is the supported value.
- dw, 16, width of the angle operand and of each result word.
- tmo, 32, maximum BUSY cycles to wait for fin before flagging an error; must be >16.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request operand valid.
- req_ready  out  1  block can accept a request.
- req_angle  in  dw  angle operand.
- op_angle  out  dw  latched operand to the CORDIC datapath.
- bgn  out  1  start strobe to the controller.
- init_in  in  1  controller init output.
- ld_in  in  1  controller ld output.
- fin  in  1  controller fin output.
- itr  out  rndw  iteration count to the controller and the datapath.
- res_x  in  dw  datapath result X, valid when fin=1.
- res_y  in  dw  datapath result Y, valid when fin=1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_x  out  dw  captured X.
- rsp_y  out  dw  captured Y.
- rsp_err  out  1  job timed out; rsp_x and rsp_y are not valid.

Behaviour:
- Reset (rst_n=0 at clk edge): state=S_IDLE; bgn=0, rsp_valid=0, rsp_err=0; itr, op_angle, rsp_x, rsp_y and the watchdog all 0. Reset mid-job abandons the job with no response.
- FSM states: S_IDLE, S_START, S_BUSY, S_DONE.
- Output decode: req_ready=1 only in S_IDLE; bgn=1 only in S_START; rsp_valid=1 only in S_DONE. All are decoded from registered state.
- S_IDLE: on req_valid, latch req_angle into op_angle and go to S_START.
- S_START: hold bgn high until init_in=1 is sampled, then go to S_BUSY and clear the watchdog. With the standard controller this takes exactly 1 cycle.
- S_BUSY, normal completion: watchdog increments each cycle. If fin=1, capture res_x/res_y into rsp_x/rsp_y, set rsp_err=0, go to S_DONE.
- S_BUSY, timeout: if fin=0 and the watchdog reaches tmo-1, set rsp_err=1, leave rsp_x/rsp_y unchanged, go to S_DONE.
- S_BUSY, simultaneous fin and timeout: fin wins.
- S_DONE: hold rsp_* stable until rsp_ready=1, then go to S_IDLE. A new request cannot be accepted in the same cycle as response acceptance.
- Iteration counter (independent of FSM state):
  - init_in=1: itr<=0; this has priority over ld_in.
  - else ld_in=1: itr<=itr+1, mod 2^rndw (15 wraps to 0).
- fin, init_in or ld_in outside the expected state: ignored by the FSM. The counter still follows init_in/ld_in.
- Nominal timing with rndw=4 (request accepted at cycle 0):
  - cycle 1: bgn=1.
  - cycles 2..17: itr=0..15.
  - cycle 18: fin=1.
  - cycle 19: rsp_valid=1.
  - Latency is 19 cycles from acceptance to response.
- Watchdog width is clog2(tmo). It saturates and never wraps while in S_BUSY.

Decomposition:
- Shared package cordic_pkg holds:
  - the FSM state encodings S_IDLE=2'b00, S_START=2'b01, S_BUSY=2'b10, S_DONE=2'b11;
  - default widths RNDW=4, DW=16;
  - the final-iteration constant ITR_LAST=15, also used by the controller.
- One natural sub-module: cordic_itr_cnt, the init/ld-driven itr counter, reused by datapath benches.

Test Plan:
- Single job with req_angle=16'h2000, bench controller model nominal, rsp_ready=1 -> bgn high for 1 cycle; itr sequences 0..15; rsp_valid at cycle 19; rsp_x/rsp_y equal the model's res_x/res_y; rsp_err=0.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_x/rsp_y/rsp_valid stable; req_ready=0 throughout; IDLE on the cycle after rsp_ready=1.
- Timeout: controller model never asserts fin, tmo=32 -> rsp_valid with rsp_err=1 exactly 32 cycles after S_BUSY entry; rsp_x/rsp_y keep their previous values.
- Fin and timeout in the same cycle (fin asserted on BUSY cycle 31, tmo=32) -> rsp_err=0 and the result is captured.
- Reset mid-job: rst_n=0 at itr=7 -> next cycle itr=0, bgn=0, rsp_valid=0, req_ready=1; a stale fin in S_IDLE produces no response.
- Back-to-back jobs with angles 16'h1000 then 16'hF000 -> two responses in order; op_angle updates only on request acceptance; itr restarts at 0 on the second init.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC host sequencer, iteration counter and controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cordic_pkg;

    // Default widths for the iteration counter and the angle/result words.
    localparam int RNDW = 4;
    localparam int DW   = 16;

    // Final iteration index; the controller stops iterating when itr reaches it.
    localparam int ITR_LAST = 15;

    // Host sequencer FSM encodings.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_BUSY  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/cordic_itr_cnt.sv
// Iteration counter driven by the controller's init/ld strobes; feeds itr to controller and datapath.
// Latency: 1 cycle from init/ld sample to updated itr.
// Backpressure: none; follows init/ld every cycle regardless of sequencer state.
module cordic_itr_cnt
    import cordic_pkg::*;
#(
    parameter int rndw = RNDW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init_in,
    input  logic            ld_in,
    output logic [rndw-1:0] itr
);

    // init restarts the count and beats ld; ld steps it, wrapping at 2^rndw.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            itr <= '0;
        end else if (init_in) begin
            itr <= '0;
        end else if (ld_in) begin
            itr <= itr + rndw'(1);
        end
    end

endmodule

// File: rtl/cordic_host_seq.sv
// Host sequencer: accepts an angle job, starts the CORDIC controller, returns the result or a timeout.
// Latency: 19 cycles from request acceptance to rsp_valid with the standard controller.
// Backpressure: req_ready only in idle; rsp_* held stable until rsp_ready, one job in flight.
module cordic_host_seq
    import cordic_pkg::*;
#(
    parameter int rndw = RNDW,
    parameter int dw   = DW,
    parameter int tmo  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [dw-1:0]   req_angle,
    output logic [dw-1:0]   op_angle,
    output logic            bgn,
    input  logic            init_in,
    input  logic            ld_in,
    input  logic            fin,
    output logic [rndw-1:0] itr,
    input  logic [dw-1:0]   res_x,
    input  logic [dw-1:0]   res_y,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [dw-1:0]   rsp_x,
    output logic [dw-1:0]   rsp_y,
    output logic            rsp_err
);

    // Watchdog only needs to reach tmo-1, where the timeout fires.
    localparam int              WDW     = $clog2(tmo);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(tmo - 1);
    localparam logic [WDW-1:0]  WD_MAX  = '1;

    state_t         state;
    state_t         state_nxt;
    logic [WDW-1:0] wd;

    // One-cycle strobes from the decode process into the datapath registers.
    logic take_req;
    logic cap_res;
    logic set_tmo;
    logic wd_clr;

    // The iteration counter tracks the controller strobes independently of the FSM.
    cordic_itr_cnt #(
        .rndw (rndw)
    ) u_itr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_in (init_in),
        .ld_in   (ld_in),
        .itr     (itr)
    );

    // State register; reset abandons any job in flight without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; every output comes from the registered state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        bgn       = 1'b0;
        rsp_valid = 1'b0;
        take_req  = 1'b0;
        cap_res   = 1'b0;
        set_tmo   = 1'b0;
        wd_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    take_req  = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // bgn stays up until the controller acknowledges with init.
                bgn = 1'b1;
                if (init_in) begin
                    wd_clr    = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // A result arriving on the last allowed cycle still counts as success.
                if (fin) begin
                    cap_res   = 1'b1;
                    state_nxt = S_DONE;
                end else if (wd == WD_LAST) begin
                    set_tmo   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Going back to idle first keeps a new request out of the accept cycle.
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, watchdog and response capture, all steered by the decode strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_angle <= '0;
            wd       <= '0;
            rsp_x    <= '0;
            rsp_y    <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (take_req) begin
                op_angle <= req_angle;
            end

            // Watchdog restarts on busy entry and saturates rather than wrapping.
            if (wd_clr) begin
                wd <= '0;
            end else if (state == S_BUSY && wd != WD_MAX) begin
                wd <= wd + WDW'(1);
            end

            // A timeout leaves the previous result words in place; only the error flag moves.
            if (cap_res) begin
                rsp_x   <= res_x;
                rsp_y   <= res_y;
                rsp_err <= 1'b0;
            end else if (set_tmo) begin
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_host_seq.sv
module tb_cordic_host_seq;
    import cordic_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_angle;
    logic [15:0] op_angle;
    logic        bgn;
    logic        init_in;
    logic        ld_in;
    logic        fin;
    logic [3:0]  itr;
    logic [15:0] res_x;
    logic [15:0] res_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_x;
    logic [15:0] rsp_y;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    cordic_host_seq #(.rndw(4), .dw(16), .tmo(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_angle (req_angle),
        .op_angle  (op_angle),
        .bgn       (bgn),
        .init_in   (init_in),
        .ld_in     (ld_in),
        .fin       (fin),
        .itr       (itr),
        .res_x     (res_x),
        .res_y     (res_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: init while bgn in idle, ld until itr==15, then fin one cycle later.
    // ctl_mode 1 suppresses fin; fin_inject lets the bench force fin on chosen cycles.
    logic [1:0] ctl;
    int         ctl_mode = 0;
    logic       fin_inject = 1'b0;

    assign init_in = (ctl == 2'd0) && bgn;
    assign ld_in   = (ctl == 2'd1) && (itr != 4'(ITR_LAST));
    assign fin     = (ctl == 2'd2) || fin_inject;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl <= 2'd0;
        end else begin
            case (ctl)
                2'd0:    if (bgn) ctl <= 2'd1;
                2'd1:    if (itr == 4'(ITR_LAST)) ctl <= (ctl_mode == 0) ? 2'd2 : 2'd0;
                default: ctl <= 2'd0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] angle;
        logic [15:0] rx;
        logic [15:0] ry;
        int          mode;
        int          fin_at;
        int          hold;
        logic        exp_err;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        int          exp_lat;
    } vec_t;

    vec_t        tbl[5];
    logic [15:0] last_angle = 16'h0000;

    task automatic run_job(input vec_t v);
        int cnt;
        int bgn_extra;
        int itr_bad;
        int bad;
        int w;
        ctl_mode  = v.mode;
        rsp_ready = (v.hold == 0);
        res_x     = v.rx;
        res_y     = v.ry;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        chk("op_hold_before_accept", 32'(op_angle), 32'(last_angle));
        req_valid = 1'b1;
        req_angle = v.angle;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_angle = 16'hFFFF;
        cnt = 1;
        chk("bgn_cycle1", 32'(bgn), 32'd1);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        chk("op_angle_latched", 32'(op_angle), 32'(v.angle));
        last_angle = v.angle;
        bgn_extra = 0;
        itr_bad = 0;
        while (!rsp_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
            fin_inject = (v.fin_at != 0) && (cnt == v.fin_at);
            if (bgn) bgn_extra++;
            if (cnt >= 2 && cnt <= 17 && int'(itr) != cnt - 2) itr_bad++;
        end
        fin_inject = 1'b0;
        chk("bgn_single_cycle", 32'(bgn_extra), 32'd0);
        chk("itr_sequence", 32'(itr_bad), 32'd0);
        chk("rsp_latency", 32'(cnt), 32'(v.exp_lat));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("rsp_x", 32'(rsp_x), 32'(v.exp_x));
        chk("rsp_y", 32'(rsp_y), 32'(v.exp_y));
        if (v.hold > 0) begin
            bad = 0;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_x !== v.exp_x || rsp_y !== v.exp_y ||
                    rsp_err !== v.exp_err || req_ready !== 1'b0) bad++;
            end
            chk("backpressure_stable", 32'(bad), 32'd0);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_accept_rdy", 32'(req_ready), 32'd1);
        chk("idle_after_accept_vld", 32'(rsp_valid), 32'd0);
        chk("op_angle_stable", 32'(op_angle), 32'(v.angle));
    endtask

    initial begin
        int w;
        int bad;

        //          angle     rx        ry        mode fin_at hold err   exp_x     exp_y     lat
        tbl[0] = '{16'h2000, 16'h1234, 16'h5678, 0,   0,     0,   1'b0, 16'h1234, 16'h5678, 19};
        tbl[1] = '{16'h1000, 16'h0AAA, 16'h0555, 0,   0,     5,   1'b0, 16'h0AAA, 16'h0555, 19};
        tbl[2] = '{16'hF000, 16'h0FFF, 16'hF001, 0,   0,     0,   1'b0, 16'h0FFF, 16'hF001, 19};
        tbl[3] = '{16'h4000, 16'hDEAD, 16'hBEEF, 1,   0,     0,   1'b1, 16'h0FFF, 16'hF001, 34};
        tbl[4] = '{16'h3000, 16'h7777, 16'h8888, 1,   33,    0,   1'b0, 16'h7777, 16'h8888, 34};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_angle = 16'h0000;
        rsp_ready = 1'b1;
        res_x     = 16'h0000;
        res_y     = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bgn", 32'(bgn), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_itr", 32'(itr), 32'd0);
        chk("rst_op_angle", 32'(op_angle), 32'd0);
        chk("rst_rsp_xy", {rsp_x, rsp_y}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i]);
        end

        // Reset in the middle of a job: abandon it and return to idle.
        ctl_mode  = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_angle = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        w = 1;
        while (!(w >= 2 && itr == 4'd7) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("mid_job_itr7", 32'(itr), 32'd7);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_itr", 32'(itr), 32'd0);
        chk("mid_rst_bgn", 32'(bgn), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_op_angle", 32'(op_angle), 32'd0);
        rst_n = 1'b1;

        // A stray fin while idle must not produce a response.
        fin_inject = 1'b1;
        @(negedge clk);
        fin_inject = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bgn !== 1'b0) bad++;
        end
        chk("stale_fin_ignored", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
